// File: rtl/regfile_pkg.sv
// Shared defaults and the hardwired-zero register address for the regfile_sb
// register file and its scoreboard.
package regfile_pkg;

  localparam int DW_DEF    = 32;
  localparam int AW_DEF    = 5;
  localparam int NRD_DEF   = 2;
  localparam int NWR_DEF   = 2;
  localparam int ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_sb_if.sv
// Read, write, issue and flush bundle between a register-file client and regfile_sb.
// The master drives addresses, data and strobes. The slave returns read data, busy flags and the pending count.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int NRD = NRD_DEF,
  parameter int NWR = NWR_DEF
);

  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              flush;
  logic [AW:0]       busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy, busy_cnt
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard. The busy bits and the count update on the next edge.
// Priority order is write-clear, then issue-set, then flush. The block has no backpressure.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int NWR = NWR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NWR-1:0]     wr_en,
  input  logic [NWR*AW-1:0]  wr_addr,
  input  logic               iss_en,
  input  logic [AW-1:0]      iss_addr,
  input  logic               flush,
  output logic [2**AW-1:0]   busy,
  output logic [AW:0]        busy_cnt
);

  localparam int DEPTH = 2**AW;

  logic [DEPTH-1:0] busy_d, busy_q;
  logic [AW:0]      cnt_d, cnt_q;

  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (wr_en[k] && (wr_addr[k*AW +: AW] != AW'(ZERO_ADDR)))
        busy_d[wr_addr[k*AW +: AW]] = 1'b0;
    end
    // Issue is applied after the clears, so a same-cycle issue wins as the younger operation.
    if (iss_en && (iss_addr != AW'(ZERO_ADDR)))
      busy_d[iss_addr] = 1'b1;
    if (flush)
      busy_d = '0;
    busy_d[ZERO_ADDR] = 1'b0;

    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with a pending-write scoreboard. Reads are combinational and writes land on the next edge; there is no backpressure.
// Defining REGFILE_SB_BYPASS_EN forwards same-cycle write data to matching reads and reports them not busy.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int NRD = NRD_DEF,
  parameter int NWR = NWR_DEF
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0]    mem_d [DEPTH];
  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] busy;

  rf_scoreboard #(.AW(AW), .NWR(NWR)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .flush    (bus.flush),
    .busy     (busy),
    .busy_cnt (bus.busy_cnt)
  );

  // Ascending port order makes the highest-index writer win an address conflict.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      mem_d[i] = mem_q[i];
    for (int k = 0; k < NWR; k++) begin
      if (bus.wr_en[k] && (bus.wr_addr[k*AW +: AW] != AW'(ZERO_ADDR)))
        mem_d[bus.wr_addr[k*AW +: AW]] = bus.wr_data[k*DW +: DW];
    end
    mem_d[ZERO_ADDR] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      if (bus.rd_addr[k*AW +: AW] != AW'(ZERO_ADDR)) begin
        bus.rd_data[k*DW +: DW] = mem_q[bus.rd_addr[k*AW +: AW]];
        bus.rd_busy[k]          = busy[bus.rd_addr[k*AW +: AW]];
`ifdef REGFILE_SB_BYPASS_EN
        for (int j = 0; j < NWR; j++) begin
          if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == bus.rd_addr[k*AW +: AW])) begin
            bus.rd_data[k*DW +: DW] = bus.wr_data[j*DW +: DW];
            bus.rd_busy[k]          = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule
